// File: rtl/mac_issue_ctrl_pkg.sv
// Shared types for the MAC issue controller: decoded-instruction bundle, tracker entry, FSM states.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package mac_issue_ctrl_pkg;

    // Pipeline depth of the mac unit; one tracker entry per stage.
    localparam int MAC_DEPTH = 4;

    // Decoded instruction as produced by IDU1 (subset of fields relevant to MAC issue).
    typedef struct packed {
        logic        mac;
        logic        macrst;
        logic        legal;
        logic        nop;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
    } idu1_out_t;

    // One in-flight MAC result: destination register and whether the slot is occupied.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } mac_trk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mac_ctl_st_e;

endpackage

// File: rtl/mac_issue_ctrl_tracker.sv
// Shadow of the mac pipeline: one {valid, rd} entry per stage, with occupancy and rd match vectors.
// Latency: entry 0 loads on the issue edge; match/occupancy outputs are combinational from the entries.
// Backpressure: freeze holds every entry so the shadow stays in lockstep with mac.
//
// Ports: clk/rst_n; freeze; load_vld/load_rd (new entry 0); qa/qb/qc_addr query addresses;
//        qa/qb/qc_hit per-entry matches (valid entries with rd != 0 only); inflight and
//        inflight_nxt (occupancy now and after the coming edge).
module mac_inflight_tracker
    import mac_issue_ctrl_pkg::*;
#(
    parameter int MAC_DEPTH = mac_issue_ctrl_pkg::MAC_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           freeze,
    input  logic                           load_vld,
    input  logic [4:0]                     load_rd,
    input  logic [4:0]                     qa_addr,
    input  logic [4:0]                     qb_addr,
    input  logic [4:0]                     qc_addr,
    output logic [MAC_DEPTH-1:0]           qa_hit,
    output logic [MAC_DEPTH-1:0]           qb_hit,
    output logic [MAC_DEPTH-1:0]           qc_hit,
    output logic [$clog2(MAC_DEPTH+1)-1:0] inflight,
    output logic [$clog2(MAC_DEPTH+1)-1:0] inflight_nxt
);

    localparam int IW = $clog2(MAC_DEPTH+1);

    mac_trk_t trk_q [MAC_DEPTH];
    mac_trk_t trk_d [MAC_DEPTH];

    // Entry k mirrors mac stage k+1; the last entry falls off as mac writes back.
    always_comb begin
        for (int k = 0; k < MAC_DEPTH; k++) begin
            trk_d[k] = trk_q[k];
        end
        if (!freeze) begin
            trk_d[0] = {load_vld, load_rd};
            for (int k = 1; k < MAC_DEPTH; k++) begin
                trk_d[k] = trk_q[k-1];
            end
        end
    end

    // x0 results never create a dependency, so those entries never match.
    always_comb begin
        inflight     = '0;
        inflight_nxt = '0;
        qa_hit       = '0;
        qb_hit       = '0;
        qc_hit       = '0;
        for (int k = 0; k < MAC_DEPTH; k++) begin
            inflight     = inflight + IW'(trk_q[k].valid);
            inflight_nxt = inflight_nxt + IW'(trk_d[k].valid);
            qa_hit[k]    = trk_q[k].valid && (trk_q[k].rd != 5'd0) && (trk_q[k].rd == qa_addr);
            qb_hit[k]    = trk_q[k].valid && (trk_q[k].rd != 5'd0) && (trk_q[k].rd == qb_addr);
            qc_hit[k]    = trk_q[k].valid && (trk_q[k].rd != 5'd0) && (trk_q[k].rd == qc_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAC_DEPTH; k++) begin
                trk_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAC_DEPTH; k++) begin
                trk_q[k] <= trk_d[k];
            end
        end
    end

endmodule

// File: rtl/mac_issue_ctrl.sv
// Issue controller in front of mac: RAW/WAW hazard stalls, macrst serialisation, stall counter.
// Latency: zero; mac_ctrl is combinational from in_ctrl so mac stage 1 captures it on the issue edge.
// Backpressure: stall holds IDU1; freeze holds tracker, FSM occupancy and counter.
//
// Ports: clk/rst_n; freeze (global pipeline hold); flush (drop presented instruction);
//        in_valid/in_ctrl (decoded instruction); stall (hold IDU1); mac_ctrl (to mac);
//        inflight (tracker occupancy); drain (FSM in DRAIN); stall_cnt (saturating stall cycles).
module mac_issue_ctrl
    import mac_issue_ctrl_pkg::*;
#(
    parameter int MAC_DEPTH = mac_issue_ctrl_pkg::MAC_DEPTH,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           freeze,
    input  logic                           flush,
    input  logic                           in_valid,
    input  idu1_out_t                      in_ctrl,
    output logic                           stall,
    output idu1_out_t                      mac_ctrl,
    output logic [$clog2(MAC_DEPTH+1)-1:0] inflight,
    output logic                           drain,
    output logic [CNT_W-1:0]               stall_cnt
);

    localparam int IW = $clog2(MAC_DEPTH+1);

    mac_ctl_st_e          st_q, st_d;
    logic                 drain_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 mac_class;
    logic                 live;
    logic                 hazard;
    logic                 issue;
    logic                 issue_mac;
    logic                 load_vld;
    logic [MAC_DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;
    logic [IW-1:0]        inflight_nxt;

    mac_inflight_tracker #(
        .MAC_DEPTH (MAC_DEPTH)
    ) u_trk (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .load_vld     (load_vld),
        .load_rd      (in_ctrl.rd_addr),
        .qa_addr      (in_ctrl.rs1_addr),
        .qb_addr      (in_ctrl.rs2_addr),
        .qc_addr      (in_ctrl.rd_addr),
        .qa_hit       (hit_rs1),
        .qb_hit       (hit_rs2),
        .qc_hit       (hit_rd),
        .inflight     (inflight),
        .inflight_nxt (inflight_nxt)
    );

    // stall is built only from registered state and in_ctrl; issue is derived from it,
    // never fed back, so there is no combinational loop through IDU1.
    always_comb begin
        mac_class = (in_ctrl.mac | in_ctrl.macrst) & in_ctrl.legal & ~in_ctrl.nop;
        live      = in_valid & in_ctrl.legal & ~in_ctrl.nop & ~flush;
        // MAC after MAC to the same rd is forwarded inside mac, so WAW only applies to non-MAC writers.
        hazard    = (|hit_rs1) | (|hit_rs2) | (~mac_class & (|hit_rd));
        stall     = live & (hazard | (st_q == DRAIN) | (in_ctrl.macrst & (inflight != '0)));
        issue     = live & ~stall & ~freeze;
        issue_mac = issue & mac_class;
        // macrst produces no register result, so it does not occupy a tracker slot.
        load_vld  = issue_mac & ~in_ctrl.macrst;
        mac_ctrl  = issue_mac ? in_ctrl : '0;
    end

    // State follows next-cycle occupancy so that DRAIN hands over to IDLE in the very
    // first cycle the tracker is empty, letting the held macrst issue immediately.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: begin
                if (inflight_nxt != '0) st_d = RUN;
            end
            RUN: begin
                if (live && in_ctrl.macrst)    st_d = DRAIN;
                else if (inflight_nxt == '0)   st_d = IDLE;
            end
            DRAIN: begin
                if (flush || (inflight_nxt == '0)) begin
                    st_d = (inflight_nxt != '0) ? RUN : IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !freeze && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            drain_q <= (st_d == DRAIN);
            cnt_q   <= cnt_d;
        end
    end

    assign drain     = drain_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// Scoreboard bench: driver pushes reference-model expectations, negedge monitor compares.
module tb_mac_issue_ctrl;
    import mac_issue_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                freeze;
    logic                flush;
    logic                in_valid;
    idu1_out_t           in_ctrl;
    logic                stall;
    idu1_out_t           mac_ctrl;
    logic [2:0]          inflight;
    logic                drain;
    logic [CW-1:0]       stall_cnt;

    always #5 clk = ~clk;

    mac_issue_ctrl #(
        .MAC_DEPTH (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .mac_ctrl  (mac_ctrl),
        .inflight  (inflight),
        .drain     (drain),
        .stall_cnt (stall_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: list of pending MAC results, each with its age in unfrozen cycles.
    typedef struct { logic [4:0] rd; int age; } ent_t;
    ent_t m_q[$];
    bit   m_drn;
    int   m_cnt;

    typedef struct {
        logic      stall;
        idu1_out_t mc;
        int        infl;
        logic      drn;
        int        cnt;
    } exp_t;
    exp_t sb[$];

    bit        exp_stall_last;
    logic      obs_stall;
    idu1_out_t obs_mc;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stall",     64'(stall),     64'(e.stall));
            chk("mac_ctrl",  64'(mac_ctrl),  64'(e.mc));
            chk("inflight",  64'(inflight),  64'(e.infl));
            chk("drain",     64'(drain),     64'(e.drn));
            chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
        end
    end

    function automatic idu1_out_t mk(input bit mac, input bit macrst, input int rd, input int rs1, input int rs2);
        idu1_out_t c;
        c          = '0;
        c.mac      = mac;
        c.macrst   = macrst;
        c.legal    = 1'b1;
        c.nop      = 1'b0;
        c.rd_addr  = rd[4:0];
        c.rs1_addr = rs1[4:0];
        c.rs2_addr = rs2[4:0];
        c.imm      = $urandom;
        return c;
    endfunction

    // Called just after a rising edge: drive one cycle, record expectation, advance model.
    task automatic step(input idu1_out_t c, input logic v, input logic fl, input logic fz);
        exp_t e;
        ent_t t;
        ent_t nq[$];
        bit   live, macc, haz, st, iss;
        int   size_before;
        in_ctrl  = c;
        in_valid = v;
        flush    = fl;
        freeze   = fz;
        live = v && c.legal && !c.nop && !fl;
        macc = (c.mac || c.macrst) && c.legal && !c.nop;
        haz  = 0;
        foreach (m_q[i]) begin
            if (m_q[i].rd != 5'd0 &&
                (c.rs1_addr == m_q[i].rd || c.rs2_addr == m_q[i].rd ||
                 (!macc && c.rd_addr == m_q[i].rd)))
                haz = 1;
        end
        st  = live && (haz || m_drn || (c.macrst && m_q.size() != 0));
        iss = live && !st && !fz;
        e.stall = st;
        e.mc    = (iss && macc) ? c : '0;
        e.infl  = m_q.size();
        e.drn   = m_drn;
        e.cnt   = m_cnt;
        sb.push_back(e);
        exp_stall_last = st;

        size_before = m_q.size();
        if (st && !fz && m_cnt != (1 << CW) - 1) m_cnt++;
        if (!fz) begin
            nq = {};
            foreach (m_q[i]) begin
                if (m_q[i].age + 1 < DEPTH) begin
                    t.rd  = m_q[i].rd;
                    t.age = m_q[i].age + 1;
                    nq.push_back(t);
                end
            end
            if (iss && macc && !c.macrst) begin
                t.rd  = c.rd_addr;
                t.age = 0;
                nq.push_back(t);
            end
            m_q = nq;
        end
        if (m_drn) m_drn = !fl && (m_q.size() != 0);
        else       m_drn = live && c.macrst && (size_before != 0);

        #1;
        obs_stall = stall;
        obs_mc    = mac_ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // Present an instruction until it issues; freeze is held for loop indices fz_lo..fz_hi.
    task automatic run_reader(input idu1_out_t c, input int fz_lo, input int fz_hi,
                              output int nst, output bit seen_macrst);
        bit done;
        done        = 0;
        nst         = 0;
        seen_macrst = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            bit fz;
            fz = (i >= fz_lo && i <= fz_hi);
            step(c, 1'b1, 1'b0, fz);
            if (obs_stall) nst++;
            else if (!fz) begin
                done        = 1;
                seen_macrst = obs_mc.macrst;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL reader_timeout: not issued within 30 cycles, required issue");
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        freeze   = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_stall",    64'(stall),     64'(0));
        chk("rst_mac_ctrl", 64'(mac_ctrl),  64'(0));
        chk("rst_inflight", 64'(inflight),  64'(0));
        chk("rst_drain",    64'(drain),     64'(0));
        chk("rst_cnt",      64'(stall_cnt), 64'(0));
        m_q   = {};
        m_drn = 0;
        m_cnt = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int        n;
        bit        s;
        idu1_out_t c;
        logic      v, fl, fz;
        int        r;

        rst_n    = 1'b1;
        freeze   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        c        = '0;
        v        = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // RAW: MAC x5 <- x1*x2, then add x6,x5,x0.
        step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
        run_reader(mk(0, 0, 6, 5, 0), 99, 99, n, s);
        chk("raw_stall_cycles", 64'(n), 64'(4));
        chk("raw_stall_cnt", 64'(stall_cnt), 64'(4));
        idle(6);

        // Back-to-back MACs to the same rd: forwarded, no stall.
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
            chk("b2b_no_stall", 64'(obs_stall), 64'(0));
            chk("b2b_inflight", 64'(inflight), 64'(i + 1));
        end
        idle(6);
        chk("b2b_drained", 64'(inflight), 64'(0));

        // macrst behind two in-flight MACs.
        step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
        step(mk(1, 0, 7, 1, 2), 1'b1, 1'b0, 1'b0);
        chk("pre_macrst_inflight", 64'(inflight), 64'(2));
        step(mk(0, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        chk("macrst_first_stall", 64'(obs_stall), 64'(1));
        chk("macrst_drain", 64'(drain), 64'(1));
        run_reader(mk(0, 1, 0, 0, 0), 99, 99, n, s);
        chk("macrst_stall_cycles", 64'(n), 64'(3));
        chk("macrst_issued", 64'(s), 64'(1));
        idle(2);

        // Freeze for three cycles inside the RAW window: reader issues at T+8.
        step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
        run_reader(mk(0, 0, 6, 5, 0), 1, 3, n, s);
        chk("freeze_stall_cycles", 64'(n), 64'(7));
        idle(6);

        // x0 destination never creates a hazard.
        step(mk(1, 0, 0, 1, 2), 1'b1, 1'b0, 1'b0);
        run_reader(mk(0, 0, 6, 0, 0), 99, 99, n, s);
        chk("x0_no_stall", 64'(n), 64'(0));
        idle(6);

        // WAW: non-MAC write to x5 behind a MAC to x5.
        step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
        run_reader(mk(0, 0, 5, 1, 2), 99, 99, n, s);
        chk("waw_stall_cycles", 64'(n), 64'(4));
        idle(6);

        // Reset with three MACs in flight, then a reader of their rd.
        for (int i = 0; i < 3; i++) step(mk(1, 0, 5, 1, 2), 1'b1, 1'b0, 1'b0);
        chk("pre_reset_inflight", 64'(inflight), 64'(3));
        do_reset();
        run_reader(mk(0, 0, 6, 5, 5), 99, 99, n, s);
        chk("post_reset_no_stall", 64'(n), 64'(0));

        // Randomised traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) do_reset();
            if (!(exp_stall_last && $urandom_range(0, 9) < 8)) begin
                r          = $urandom_range(0, 99);
                c          = '0;
                c.mac      = (r < 40);
                c.macrst   = (r >= 40 && r < 47);
                c.legal    = ($urandom_range(0, 19) != 0);
                c.nop      = ($urandom_range(0, 14) == 0);
                c.rd_addr  = 5'($urandom_range(0, 7));
                c.rs1_addr = 5'($urandom_range(0, 7));
                c.rs2_addr = 5'($urandom_range(0, 7));
                c.imm      = $urandom;
                v          = ($urandom_range(0, 9) != 0);
            end
            fl = ($urandom_range(0, 14) == 0);
            fz = ($urandom_range(0, 9) == 0);
            step(c, v, fl, fz);
        end
        idle(2);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
